// File: rtl/apb_mem_slave_v2.sv
// APB4 memory slave: register-file storage, byte strobes, fixed wait states, PSLVERR on bad addresses.
// Define APB_MEM_SLAVE_PROT_EN to make the top quarter of the word space writable only with PPROT[0]=1.
module apb_mem_slave_v2 #(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 256,
  parameter int ADDR_WIDTH  = 32,
  parameter int WAIT_STATES = 0
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic                    PWRITE,
  input  logic [ADDR_WIDTH-1:0]   PADDR,
  input  logic [DATA_WIDTH-1:0]   PWDATA,
  input  logic [DATA_WIDTH/8-1:0] PSTRB,
  input  logic [2:0]              PPROT,
  output logic                    PREADY,
  output logic [DATA_WIDTH-1:0]   PRDATA,
  output logic                    PSLVERR
);

  localparam int NB        = DATA_WIDTH / 8;
  localparam int LSB       = $clog2(NB);
  localparam int IDX_W     = $clog2(DEPTH);
  localparam int MEM_BYTES = DEPTH * NB;
  localparam int CMP_W     = (ADDR_WIDTH > 20) ? ADDR_WIDTH : 20;
  localparam int PRIV_BASE = 3 * DEPTH / 4;

  typedef enum logic {IDLE, ACCESS} state_e;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  state_e                state_q;
  logic [3:0]            cnt_q;
  logic [IDX_W-1:0]      idx_q;
  logic                  write_q;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [NB-1:0]         strb_q;
  logic [DATA_WIDTH-1:0] prdata_q;

  logic [IDX_W-1:0]      idx_d;
  logic                  misaligned;
  logic                  out_of_range;
  logic                  prot_err;
  logic                  err_d;
  logic                  setup;
  logic                  pready;
  logic                  mem_we;
  logic                  unused_prot;

  assign idx_d = PADDR[LSB +: IDX_W];

  generate
    if (LSB > 0) begin : g_align
      assign misaligned = |PADDR[LSB-1:0];
    end else begin : g_no_align
      assign misaligned = 1'b0;
    end
  endgenerate

  // Compare in a width that always holds MEM_BYTES, even for narrow PADDR.
  assign out_of_range = CMP_W'(PADDR) >= CMP_W'(MEM_BYTES);

`ifdef APB_MEM_SLAVE_PROT_EN
  assign prot_err    = PWRITE && !PPROT[0] && (idx_d >= IDX_W'(PRIV_BASE));
  assign unused_prot = ^PPROT[2:1];
`else
  assign prot_err    = 1'b0;
  assign unused_prot = ^PPROT;
`endif

  assign err_d  = misaligned || out_of_range || prot_err;
  assign setup  = PSEL && !PENABLE;
  assign pready = (state_q == ACCESS) && (cnt_q == 4'd0) && PSEL && PENABLE;
  assign mem_we = pready && write_q && !err_q;

  // A setup phase is accepted in either state; in ACCESS it abandons the current transfer.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      idx_q    <= '0;
      write_q  <= 1'b0;
      err_q    <= 1'b0;
      wdata_q  <= '0;
      strb_q   <= '0;
      prdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (setup) begin
            state_q <= ACCESS;
            cnt_q   <= 4'(WAIT_STATES);
            idx_q   <= idx_d;
            write_q <= PWRITE;
            err_q   <= err_d;
            wdata_q <= PWDATA;
            strb_q  <= PSTRB;
            if (!PWRITE) begin
              prdata_q <= err_d ? '0 : mem_q[idx_d];
            end
          end
        end
        ACCESS: begin
          if (setup) begin
            cnt_q   <= 4'(WAIT_STATES);
            idx_q   <= idx_d;
            write_q <= PWRITE;
            err_q   <= err_d;
            wdata_q <= PWDATA;
            strb_q  <= PSTRB;
            if (!PWRITE) begin
              prdata_q <= err_d ? '0 : mem_q[idx_d];
            end
          end else if (!PSEL || pready) begin
            state_q <= IDLE;
          end else if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge PCLK) begin
    if (mem_we) begin
      for (int i = 0; i < NB; i++) begin
        if (strb_q[i]) begin
          mem_q[idx_q][i*8 +: 8] <= wdata_q[i*8 +: 8];
        end
      end
    end
  end

  assign PREADY  = pready;
  assign PSLVERR = pready && err_q;
  assign PRDATA  = prdata_q;

endmodule

// File: tb/tb_apb_mem_slave_v2.sv
// Randomised scoreboard bench for apb_mem_slave_v2: driver pushes expected responses, monitor checks completions.
`timescale 1ns/1ps
module tb_apb_mem_slave_v2;

  localparam int DW    = 32;
  localparam int DEPTH = 256;
  localparam int AW    = 32;
  localparam int WS    = 2;
  localparam int NB    = DW / 8;
`ifdef APB_MEM_SLAVE_PROT_EN
  localparam bit PROT_EN = 1'b1;
`else
  localparam bit PROT_EN = 1'b0;
`endif

  logic          PCLK = 1'b0;
  logic          PRESET = 1'b1;
  logic          PSEL = 1'b0;
  logic          PENABLE = 1'b0;
  logic          PWRITE = 1'b0;
  logic [AW-1:0] PADDR = '0;
  logic [DW-1:0] PWDATA = '0;
  logic [NB-1:0] PSTRB = '0;
  logic [2:0]    PPROT = '0;
  logic          PREADY;
  logic [DW-1:0] PRDATA;
  logic          PSLVERR;

  always #5 PCLK = ~PCLK;

  apb_mem_slave_v2 #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (AW),
    .WAIT_STATES(WS)
  ) dut (
    .PCLK    (PCLK),
    .PRESET  (PRESET),
    .PSEL    (PSEL),
    .PENABLE (PENABLE),
    .PWRITE  (PWRITE),
    .PADDR   (PADDR),
    .PWDATA  (PWDATA),
    .PSTRB   (PSTRB),
    .PPROT   (PPROT),
    .PREADY  (PREADY),
    .PRDATA  (PRDATA),
    .PSLVERR (PSLVERR)
  );

  typedef struct {
    logic          wr;
    logic [31:0]   addr;
    logic [DW-1:0] prdata;
    logic          slverr;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] model_mem [DEPTH];
  logic [DW-1:0] last_rd = '0;
  int            checks = 0;
  int            errors = 0;
  int            waitcnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference behaviour: byte-addressed word memory, bad addresses answer with an error and zero data.
  function automatic exp_t model(input logic wr, input logic [31:0] addr, input logic [DW-1:0] data,
                                 input logic [NB-1:0] strb, input logic [2:0] prot);
    exp_t e;
    bit   err;
    int   idx;
    idx = int'(addr / NB);
    err = (addr % NB != 0) || (addr >= DEPTH * NB);
    if (PROT_EN && wr && !err && idx >= 3 * DEPTH / 4 && !prot[0]) err = 1'b1;
    if (wr) begin
      if (!err) begin
        for (int b = 0; b < NB; b++) begin
          if (strb[b]) model_mem[idx][8*b +: 8] = data[8*b +: 8];
        end
      end
    end else begin
      last_rd = err ? '0 : model_mem[idx];
    end
    e.wr     = wr;
    e.addr   = addr;
    e.slverr = err;
    e.prdata = last_rd;
    return e;
  endfunction

  always @(negedge PCLK) begin
    exp_t e;
    if (PRESET) begin
      waitcnt = 0;
    end else if (PREADY) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pready: got PREADY=1, expected no completion (t=%0t)", $time);
      end else begin
        e = exp_q.pop_front();
        $display("xfer %s addr=%08h prdata=%08h pslverr=%0b waits=%0d",
                 e.wr ? "WR" : "RD", e.addr, PRDATA, PSLVERR, waitcnt);
        chk("pslverr", 64'(PSLVERR), 64'(e.slverr));
        chk("prdata", 64'(PRDATA), 64'(e.prdata));
        chk("wait_cycles", 64'(waitcnt), 64'(WS));
      end
      waitcnt = 0;
    end else begin
      if (PSLVERR) begin
        checks++;
        errors++;
        $display("FAIL pslverr_without_pready: got PSLVERR=1, expected 0 (t=%0t)", $time);
      end
      if (PSEL && PENABLE) waitcnt++;
      else waitcnt = 0;
    end
  end

  // Called just after a rising edge; returns just after the completion edge with PSEL still high.
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [DW-1:0] data,
                      input logic [NB-1:0] strb, input logic [2:0] prot);
    bit done;
    int n;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr;
    PWDATA = data; PSTRB = strb; PPROT = prot;
    exp_q.push_back(model(wr, addr, data, strb, prot));
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    done = 1'b0;
    n = 0;
    while (!done) begin
      @(negedge PCLK);
      done = PREADY;
      @(posedge PCLK); #1;
      n++;
      if (!done && n > 40) begin
        checks++;
        errors++;
        $display("FAIL timeout: got no PREADY after %0d cycles, expected %0d waits", n, WS);
        exp_q.delete();
        done = 1'b1;
      end
    end
  endtask

  task automatic idle_cycle();
    PSEL = 1'b0; PENABLE = 1'b0;
    @(posedge PCLK); #1;
  endtask

  // Write that never completes: dropped by PSEL low, or by a new setup when restart is set.
  task automatic abandon_write(input logic [31:0] addr, input logic [DW-1:0] data, input bit restart);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = addr;
    PWDATA = data; PSTRB = '1; PPROT = 3'b001;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
    if (!restart) idle_cycle();
  endtask

  function automatic logic [31:0] pick_valid_addr();
    if ($urandom_range(0, 3) == 0) return 32'h300 + 32'($urandom_range(0, 15)) * 4;
    return 32'($urandom_range(0, 15)) * 4;
  endfunction

  function automatic logic [31:0] pick_bad_addr();
    logic [31:0] a;
    case ($urandom_range(0, 2))
      0:       a = pick_valid_addr() + 32'($urandom_range(1, NB - 1));
      1:       a = 32'h400 + 32'($urandom_range(0, 255)) * 4;
      default: a = 32'h400 | $urandom();
    endcase
    return a;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no end of test, expected completion within 1 ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset values
    repeat (2) @(posedge PCLK);
    #1;
    chk("reset_pready", 64'(PREADY), 64'(0));
    chk("reset_prdata", 64'(PRDATA), 64'(0));
    chk("reset_pslverr", 64'(PSLVERR), 64'(0));
    PRESET = 1'b0;
    @(posedge PCLK); #1;

    // Give every word the random traffic may read a known value.
    for (int i = 0; i < 16; i++) xfer(1'b1, 32'(i * 4), $urandom(), '1, 3'b001);
    for (int i = 0; i < 16; i++) xfer(1'b1, 32'h300 + 32'(i * 4), $urandom(), '1, 3'b001);

    // Basic write/read, byte strobes, errors
    xfer(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 3'b000);
    xfer(1'b0, 32'h10, $urandom(), 4'h0, 3'b000);
    xfer(1'b1, 32'h20, 32'h11223344, 4'hF, 3'b000);
    xfer(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 3'b000);
    xfer(1'b0, 32'h20, '0, 4'h0, 3'b000);
    xfer(1'b1, 32'h400, 32'h0BADF00D, 4'hF, 3'b000);
    xfer(1'b0, 32'h13, '0, 4'h0, 3'b000);
    xfer(1'b0, 32'h10, '0, 4'h0, 3'b000);
    idle_cycle();

    // Abort and restart leave the target word unchanged
    abandon_write(32'h30, 32'h55, 1'b0);
    xfer(1'b0, 32'h30, '0, 4'h0, 3'b000);
    abandon_write(32'h34, 32'h66, 1'b1);
    xfer(1'b0, 32'h34, '0, 4'h0, 3'b000);

    // Privileged region
    xfer(1'b1, 32'h300, 32'h12345678, 4'hF, 3'b000);
    xfer(1'b0, 32'h300, '0, 4'h0, 3'b000);
    xfer(1'b1, 32'h300, 32'h12345678, 4'hF, 3'b001);
    xfer(1'b0, 32'h300, '0, 4'h0, 3'b000);
    idle_cycle();

    // Random traffic, mixing back-to-back transfers, idles, aborts and restarts
    for (int n = 0; n < 300; n++) begin
      int kind;
      kind = $urandom_range(0, 9);
      if (kind <= 5) begin
        xfer(1'($urandom_range(0, 1)), pick_valid_addr(), $urandom(), 4'($urandom()), 3'($urandom()));
      end else if (kind == 6) begin
        xfer(1'($urandom_range(0, 1)), pick_bad_addr(), $urandom(), 4'($urandom()), 3'($urandom()));
      end else if (kind == 7) begin
        idle_cycle();
      end else if (kind == 8) begin
        abandon_write(pick_valid_addr(), $urandom(), 1'b0);
      end else begin
        abandon_write(pick_valid_addr(), $urandom(), 1'b1);
        xfer(1'b0, pick_valid_addr(), '0, 4'h0, 3'b000);
      end
    end
    idle_cycle();

    // Reset in the middle of a read's wait phase clears the outputs at once
    xfer(1'b1, 32'h8, 32'hCAFEF00D, 4'hF, 3'b001);
    PWRITE = 1'b0; PADDR = 32'h8; PENABLE = 1'b0;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(negedge PCLK); #2;
    PRESET = 1'b1;
    #1;
    chk("midreset_pready", 64'(PREADY), 64'(0));
    chk("midreset_prdata", 64'(PRDATA), 64'(0));
    chk("midreset_pslverr", 64'(PSLVERR), 64'(0));
    PSEL = 1'b0; PENABLE = 1'b0;
    @(posedge PCLK); #1;
    PRESET = 1'b0;
    repeat (4) idle_cycle();

    chk("pending_completions", 64'(exp_q.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
